mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: max cycles dmem_req held without dmem_ack before bus error (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 ex_valid  input  1  execute-stage instruction valid.
REQ-005 ex_mem_read / ex_mem_write  input  1 each  load / store request from execute.
REQ-006 ex_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 ex_addr / ex_wdata  input  32 each  byte address (ALU result) / store data.
REQ-008 ex_rd  input  5  load destination register.
REQ-009 stall  output  1  holds execute and earlier stages.
REQ-010 dmem_req, dmem_we  output  1 each  bus request / write strobe; dmem_addr  output  32  word address (bits[1:0]=0); dmem_be  output  4  byte enables; dmem_wdata  output  32  lane-replicated store data.
REQ-011 dmem_ack  input  1  one-cycle completion; dmem_rdata  input  32  read word, valid with ack.
REQ-012 wb_valid  output  1  load result pulse; wb_rd  output  5; wb_data  output  32.
REQ-013 bus_err  output  1  timeout pulse; misaligned  output  1  misalignment pulse (macro-dependent).

Function
REQ-014 FSM states IDLE, BUSY; mem_op = ex_valid & (ex_mem_read | ex_mem_write) & funct3 in the supported set for that operation (stores: 000/001/010 only).
REQ-015 IDLE & mem_op: latch op, size, address, data, rd; next cycle state BUSY with dmem_req=1 (request latency 1 cycle).
REQ-016 Read and write both asserted: read wins; write ignored.
REQ-017 Unsupported funct3: no request, no stall, no wb_valid.
REQ-018 dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata constant throughout BUSY.
REQ-019 dmem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; reads drive same mask.
REQ-020 dmem_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-021 stall = (IDLE & mem_op) | (BUSY & ~dmem_ack & ~timeout); stall 0 in the ack cycle.
REQ-022 BUSY & dmem_ack: next cycle IDLE, dmem_req=0; for loads wb_valid=1 for exactly one cycle with wb_rd and extracted data.
REQ-023 Load extraction: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-024 Wait counter clears on entry to BUSY, increments each BUSY cycle without ack; reaching WAIT_LIMIT-1 without ack = timeout: dmem_req drops, bus_err pulses 1 cycle, no wb_valid, return IDLE.
REQ-025 dmem_ack in IDLE is ignored; ack in the timeout cycle takes priority over timeout.
REQ-026 Stores never assert wb_valid.

Reset
REQ-027 rst_n=0 at a clock edge: state IDLE, counter 0, dmem_req/dmem_we/wb_valid/bus_err/misaligned 0, dmem_addr/dmem_be/dmem_wdata/wb_rd/wb_data 0.
REQ-028 Reset in BUSY aborts the access; dmem_req low on the following cycle; late ack ignored.

Configuration
REQ-029 Macro MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request, pulses misaligned for one cycle, no stall, no wb_valid.
REQ-030 Macro undefined: misaligned tied 0; address low bits forced to natural alignment (half clears bit0, word clears bits[1:0]) and access issued normally.

Structure
REQ-031 Package mem_pkg holds state enum, funct3 encoding constants and byte-enable width constant.
REQ-032 Sub-module load_align (combinational: rdata, addr[1:0], funct3 -> wb_data) instantiated once.

Verification
REQ-033 LW addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> stall 4 cycles, wb_valid next cycle, wb_data 0xDEADBEEF.
REQ-034 LB addr 0x103, rdata 0x80112233 -> dmem_be 4'b1000, wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x202, wdata 0x0000ABCD -> dmem_we 1, dmem_be 4'b1100, dmem_wdata 0xABCDABCD, no wb_valid.
REQ-036 LW, no ack, WAIT_LIMIT=16 -> bus_err pulse 16 cycles after req rise, dmem_req 0, stall 0.
REQ-037 rst_n low during BUSY -> dmem_req 0 next cycle; subsequent ack produces no wb_valid.
REQ-038 LW addr 0x102 -> with MEM_MISALIGN_TRAP_EN misaligned pulse, no req; without, dmem_addr 0x100, be 4'b1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and encodings for the data-memory access controller.
// No logic; state enum, funct3 access-size codes, byte-enable helper.
// Imported by mem_access_ctrl and load_align.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // size is funct3[1:0]: 00 byte, 01 half, otherwise word
    function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the lane and sign/zero-extends per funct3.
// Latency 0 (purely combinational).
// No flow control; result is meaningful only alongside dmem_ack.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] wb_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    wb_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   wb_data = {24'b0, byte_sel};
            F3_H:    wb_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   wb_data = {16'b0, half_sel};
            default: wb_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: one outstanding data-bus access with timeout; MEM_MISALIGN_TRAP_EN enables misalign trap.
// Request 1 cycle after accept; wb_valid/bus_err/misaligned are registered pulses 1 cycle after ack/timeout/accept.
// Backpressure via stall: held from accept until the ack or timeout cycle.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [31:0]     ex_addr,
    input  logic [31:0]     ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [31:0]     dmem_addr,
    output logic [BE_W-1:0] dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_ack,
    input  logic [31:0]     dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [31:0]     wb_data,
    output logic            bus_err,
    output logic            misaligned
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q, wb_data_q;
    logic [BE_W-1:0] be_q;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic [4:0]      rd_q, wb_rd_q;
    logic            wb_valid_q, bus_err_q;

    logic        rd_op, wr_op, ld_ok, st_ok, mem_op, trap, go, timeout, busy, ld_done;
    logic        is_half, is_word;
    logic [1:0]  lane;
    logic [31:0] wdata_rep, align_data;

    // Read wins when both strobes are set.
    assign rd_op   = ex_mem_read;
    assign wr_op   = ex_mem_write & ~ex_mem_read;
    assign ld_ok   = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
                     (ex_funct3 == F3_BU) || (ex_funct3 == F3_HU);
    assign st_ok   = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W);
    assign mem_op  = ex_valid & ((rd_op & ld_ok) | (wr_op & st_ok));
    assign is_half = (ex_funct3[1:0] == 2'b01);
    assign is_word = (ex_funct3[1:0] == 2'b10);
    assign lane    = is_word ? 2'b00 : (is_half ? {ex_addr[1], 1'b0} : ex_addr[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign trap = (is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!rst_n) misaligned_q <= 1'b0;
        else        misaligned_q <= (state_q == IDLE) & mem_op & trap;
    end
    assign misaligned = misaligned_q;
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign busy    = (state_q == BUSY);
    assign go      = (state_q == IDLE) & mem_op & ~trap;
    assign timeout = busy & ~dmem_ack & (cnt_q == LIMIT_M1);
    assign ld_done = busy & dmem_ack & ~we_q;
    assign stall   = go | (busy & ~dmem_ack & ~timeout);

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   wdata_rep = {4{ex_wdata[7:0]}};
            2'b01:   wdata_rep = {2{ex_wdata[15:0]}};
            default: wdata_rep = ex_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                end
            end
            BUSY: begin
                if (dmem_ack || timeout) state_d = IDLE;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (lane_q),
        .funct3  (f3_q),
        .wb_data (align_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= '0;
            wdata_q    <= 32'd0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= ld_done;
            bus_err_q  <= timeout;
            if (go) begin
                we_q    <= wr_op;
                addr_q  <= {ex_addr[31:2], 2'b00};
                be_q    <= byte_en(ex_funct3[1:0], lane);
                wdata_q <= wdata_rep;
                f3_q    <= ex_funct3;
                lane_q  <= lane;
                rd_q    <= ex_rd;
            end
            if (ld_done) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= align_data;
            end
        end
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (default build, WAIT_LIMIT=16).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, bus_err, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.WAIT_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_err(bus_err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rdst;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wbv;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        ex_valid     = v;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = a;
        ex_wdata     = wd;
        ex_rd        = r;
    endtask

    task automatic run_vec(input int i);
        vec_t t;
        t = vecs[i];
        @(negedge clk);
        drive_op(t.v, t.rd, t.wr, t.f3, t.addr, t.wdata, t.rdst);
        #1;
        chk($sformatf("v%0d stall_accept", i), 32'(stall), 32'(t.exp_req));
        @(negedge clk);
        chk($sformatf("v%0d req", i), 32'(dmem_req), 32'(t.exp_req));
        if (t.exp_req) begin
            chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(t.exp_we));
            chk($sformatf("v%0d addr", i), dmem_addr, t.exp_addr);
            chk($sformatf("v%0d be", i), 32'(dmem_be), 32'(t.exp_be));
            if (t.exp_we) chk($sformatf("v%0d wdata", i), dmem_wdata, t.exp_wdata);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = t.rdata;
        #1;
        chk($sformatf("v%0d stall_ack", i), 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk($sformatf("v%0d req_after", i), 32'(dmem_req), 32'd0);
        chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(t.exp_wbv));
        if (t.exp_wbv) begin
            chk($sformatf("v%0d wb_data", i), wb_data, t.exp_wb);
            chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(t.rdst));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int t_stall;
        int t_err;
        int err_cycles;
        int saw_wb;

        //          v  rd wr f3      addr      wdata         rdata         rd     req we eaddr     be       ewdata        wbv ewb
        vecs[0]  = '{1, 1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 5'd5,  1, 0, 32'h100, 4'b1000, 32'h0,        1, 32'hFFFFFF80};
        vecs[1]  = '{1, 1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 5'd6,  1, 0, 32'h100, 4'b1000, 32'h0,        1, 32'h00000080};
        vecs[2]  = '{1, 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        5'd7,  1, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 32'h0};
        vecs[3]  = '{1, 1, 0, 3'b001, 32'h102, 32'h0,        32'h80112233, 5'd8,  1, 0, 32'h100, 4'b1100, 32'h0,        1, 32'hFFFF8011};
        vecs[4]  = '{1, 1, 0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 5'd9,  1, 0, 32'h100, 4'b0011, 32'h0,        1, 32'h0000F00D};
        vecs[5]  = '{1, 1, 0, 3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 5'd10, 1, 0, 32'h100, 4'b1111, 32'h0,        1, 32'hCAFEF00D};
        vecs[6]  = '{1, 0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0,        5'd0,  1, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 0, 32'h0};
        vecs[7]  = '{1, 0, 1, 3'b010, 32'h404, 32'h11223344, 32'h0,        5'd0,  1, 1, 32'h404, 4'b1111, 32'h11223344, 0, 32'h0};
        vecs[8]  = '{1, 1, 0, 3'b011, 32'h500, 32'h0,        32'h55555555, 5'd1,  0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0};
        vecs[9]  = '{1, 0, 1, 3'b100, 32'h600, 32'h77777777, 32'h0,        5'd2,  0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0};
        vecs[10] = '{1, 1, 1, 3'b000, 32'h101, 32'hFFFFFFFF, 32'h00007F00, 5'd11, 1, 0, 32'h100, 4'b0010, 32'h0,        1, 32'h0000007F};
        vecs[11] = '{1, 1, 0, 3'b001, 32'h103, 32'h0,        32'hABCD0000, 5'd12, 1, 0, 32'h100, 4'b1100, 32'h0,        1, 32'hFFFFABCD};
        vecs[12] = '{0, 1, 0, 3'b010, 32'h700, 32'h0,        32'h12345678, 5'd13, 0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0};
        vecs[13] = '{1, 1, 0, 3'b100, 32'h102, 32'h0,        32'h00C30000, 5'd14, 1, 0, 32'h100, 4'b0100, 32'h0,        1, 32'h000000C3};

        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst we", 32'(dmem_we), 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i);

        // LW with ack three cycles after the request rises
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            #1;
            if (stall) stalls++;
            if (c == 0) chk("lw req_latency", 32'(dmem_req), 32'd0);
            if (c == 1) chk("lw req_rise", 32'(dmem_req), 32'd1);
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk("lw stall_cycles", 32'(stalls), 32'd4);
        chk("lw wb_valid", 32'(wb_valid), 32'd1);
        chk("lw wb_data", wb_data, 32'hDEADBEEF);
        chk("lw wb_rd", 32'(wb_rd), 32'd3);
        @(negedge clk);
        chk("lw wb_pulse_end", 32'(wb_valid), 32'd0);

        // No ack: timeout after WAIT_LIMIT cycles
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd4);
        @(negedge clk);
        chk("to req_rise", 32'(dmem_req), 32'd1);
        t_stall = -1;
        t_err = -1;
        err_cycles = 0;
        saw_wb = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (t_stall < 0 && !stall) begin
                t_stall  = k;
                ex_valid = 1'b0;
            end
            if (bus_err) begin
                err_cycles++;
                if (t_err < 0) begin
                    t_err = k;
                    chk("to req_at_err", 32'(dmem_req), 32'd0);
                    chk("to stall_at_err", 32'(stall), 32'd0);
                end
            end
            if (wb_valid) saw_wb = 1;
            @(negedge clk);
        end
        chk("to stall_release_offset", 32'(t_stall), 32'd15);
        chk("to bus_err_offset", 32'(t_err), 32'd16);
        chk("to bus_err_width", 32'(err_cycles), 32'd1);
        chk("to no_wb_valid", 32'(saw_wb), 32'd0);

        // Ack arriving in the would-be timeout cycle wins
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd15);
        @(negedge clk);
        repeat (15) @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A1234;
        #1;
        chk("late_ack stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk("late_ack wb_valid", 32'(wb_valid), 32'd1);
        chk("late_ack wb_data", wb_data, 32'h5A5A1234);
        chk("late_ack no_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);

        // Reset while BUSY aborts; a later ack is ignored
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd16);
        @(negedge clk);
        chk("rstbusy req_before", 32'(dmem_req), 32'd1);
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rstbusy req_after", 32'(dmem_req), 32'd0);
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h87654321;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("rstbusy no_wb_1", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("rstbusy no_wb_2", 32'(wb_valid), 32'd0);
        chk("rstbusy req_idle", 32'(dmem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
